// File: rtl/debounce_edge.sv
// Synchroniser plus counter-based stability filter producing a clean level and
// registered rise/fall pulses. Define DEBOUNCE_TOGGLE_EN to add the toggle_q output.
module debounce_edge #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_W         = 8,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic db_out,
  output logic rise,
  output logic fall,
`ifdef DEBOUNCE_TOGGLE_EN
  output logic toggle_q,
`endif
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  logic                   update;

  assign s      = sync[SYNC_STAGES-1];
  assign update = (s != db_out) && (cnt == CNT_LAST);
  assign busy   = (cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_in};
    end
  end

  // Any sample matching the current level restarts the count from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_out <= RESET_LEVEL;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= update && s;
      fall <= update && !s;
      if (s == db_out) begin
        cnt <= '0;
      end else if (update) begin
        db_out <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_q <= 1'b0;
    end else if (rise) begin
      toggle_q <= !toggle_q;
    end
  end
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: a run-length model of the filter is checked
// every cycle, alongside hand-computed expectations for each scenario.
module tb_debounce_edge;

  localparam int   SYNC   = 2;
  localparam int   STABLE = 4;
  localparam logic RL     = 1'b0;

  logic clk = 1'b0;
  logic reset;
  logic d_in;
  logic db_out, rise, fall, busy;
`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle_q;
`endif

  int total = 0;
  int bad   = 0;

  debounce_edge #(
    .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .CNT_W(8), .RESET_LEVEL(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .d_in(d_in),
    .db_out(db_out),
    .rise(rise),
    .fall(fall),
`ifdef DEBOUNCE_TOGGLE_EN
    .toggle_q(toggle_q),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: s is d_in delayed by SYNC edges; the level flips once the trailing
  // STABLE samples of s all differ from it; busy means a differing run is pending.
  logic m_db, m_rise, m_fall, m_busy, m_tog;
  bit   m_valid = 0;
  bit   dq[$];
  bit   sq[$];

  task automatic model_step();
    bit s;
    bit upd;
    int run;
    if (reset) begin
      dq.delete();
      for (int i = 0; i < SYNC; i++) dq.push_back(RL);
      sq.delete();
      m_db = RL; m_rise = 0; m_fall = 0; m_busy = 0; m_tog = 0;
      m_valid = 1;
      return;
    end
    if (!m_valid) return;
    s = dq[0];
    dq.push_back(d_in);
    while (dq.size() > SYNC) void'(dq.pop_front());
    sq.push_back(s);
    while (sq.size() > 2 * STABLE) void'(sq.pop_front());
    run = 0;
    for (int i = sq.size() - 1; i >= 0; i--) begin
      if (sq[i] == m_db) break;
      run++;
    end
    upd = (run >= STABLE);
    if (m_rise) m_tog = !m_tog;
    m_rise = upd && s;
    m_fall = upd && !s;
    if (upd) m_db = s;
    m_busy = !upd && (run > 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("model db_out", db_out, m_db);
      check("model rise", rise, m_rise);
      check("model fall", fall, m_fall);
      check("model busy", busy, m_busy);
`ifdef DEBOUNCE_TOGGLE_EN
      check("model toggle_q", toggle_q, m_tog);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int n_rise, n_fall;

  initial begin
    reset = 1'b1;
    d_in  = 1'b1;

    // Reset held with d_in high, then released low: nothing moves.
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t1 reset db_out c%0d", k), db_out, 1'b0);
      check($sformatf("t1 reset busy c%0d", k), busy, 1'b0);
      check($sformatf("t1 reset pulses c%0d", k), rise | fall, 1'b0);
    end
    reset = 1'b0;
    d_in  = 1'b0;
    n_rise = 0; n_fall = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_rise += int'(rise); n_fall += int'(fall);
      check($sformatf("t1 idle db_out c%0d", k), db_out, 1'b0);
      check($sformatf("t1 idle busy c%0d", k), busy, 1'b0);
    end
    check("t1 no rise", n_rise == 0, 1'b1);
    check("t1 no fall", n_fall == 0, 1'b1);

    // Clean press: level follows at edge 6, busy for edges 3..5.
    d_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("t2 db_out e%0d", k), db_out, logic'(k >= 6));
      check($sformatf("t2 rise e%0d", k), rise, logic'(k == 6));
      check($sformatf("t2 busy e%0d", k), busy, logic'(k >= 3 && k <= 5));
      check($sformatf("t2 fall e%0d", k), fall, 1'b0);
    end

    // Clean release.
    d_in = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("t4 db_out e%0d", k), db_out, logic'(k < 6));
      check($sformatf("t4 fall e%0d", k), fall, logic'(k == 6));
      check($sformatf("t4 rise e%0d", k), rise, 1'b0);
    end

    // Bounce 1,1,0,1...: the dip restarts the count, level follows at edge 9.
    n_rise = 0;
    for (int k = 1; k <= 14; k++) begin
      d_in = (k == 3) ? 1'b0 : 1'b1;
      tick();
      n_rise += int'(rise);
      check($sformatf("t3 db_out e%0d", k), db_out, logic'(k >= 9));
      check($sformatf("t3 rise e%0d", k), rise, logic'(k == 9));
      check($sformatf("t3 busy e%0d", k), busy,
            logic'((k >= 3 && k <= 4) || (k >= 6 && k <= 8)));
    end
    check("t3 single rise", n_rise == 1, 1'b1);

    // Reset mid-count (count at 2) discards the pending change silently.
    d_in = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check("t5 busy before reset", busy, 1'b1);
    check("t5 db_out before reset", db_out, 1'b1);
    reset = 1'b1;
    tick();
    check("t5 db_out after reset", db_out, RL);
    check("t5 busy after reset", busy, 1'b0);
    check("t5 rise after reset", rise, 1'b0);
    check("t5 fall after reset", fall, 1'b0);
    reset = 1'b0;
    n_rise = 0; n_fall = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_rise += int'(rise); n_fall += int'(fall);
    end
    check("t5 quiet after release", (n_rise + n_fall) == 0, 1'b1);
    check("t5 db_out settled", db_out, 1'b0);

    // Release reset with d_in high: one normal debounce, one rise.
    reset = 1'b1;
    d_in  = 1'b1;
    tick();
    reset = 1'b0;
    n_rise = 0; n_fall = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_rise += int'(rise); n_fall += int'(fall);
      check($sformatf("t5b db_out e%0d", k), db_out, logic'(k >= 6));
    end
    check("t5b one rise", n_rise == 1, 1'b1);
    check("t5b no fall", n_fall == 0, 1'b1);

    // Three press/release pairs from a fresh reset.
    reset = 1'b1;
    d_in  = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    for (int p = 0; p < 3; p++) begin
      d_in = 1'b1;
      for (int k = 1; k <= 7; k++) begin
        tick();
        if (k == 6) check($sformatf("t6 rise p%0d", p), rise, 1'b1);
`ifdef DEBOUNCE_TOGGLE_EN
        if (k == 6) check($sformatf("t6 toggle old p%0d", p), toggle_q, logic'(p % 2 == 1));
        if (k == 7) check($sformatf("t6 toggle new p%0d", p), toggle_q, logic'(p % 2 == 0));
`endif
      end
      d_in = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (k == 6) check($sformatf("t6 fall p%0d", p), fall, 1'b1);
      end
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
